// File: rtl/bcd_event_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_event_counter
//  Description : Debounced push-button two-digit BCD counter (00-99) that
//                feeds the seven-segment display mux/decoder.
//                Each raw button goes through a 2-flop synchroniser and a
//                LOW/HIGH debounce filter. A filtered 0->1 flip makes a
//                one-cycle event. The count updates on the following edge
//                with priority clr > (up XOR dn).
//  Optional    : AUTO_COUNT_EN - free-running PRESCALE_W-bit prescaler whose
//                all-ones cycle acts as an extra up event.
//  Ports       : clock   in  1  system clock, rising edge
//                reset   in  1  synchronous, active-low reset
//                btn_up  in  1  raw up button, active-high
//                btn_dn  in  1  raw down button, active-high
//                btn_clr in  1  raw clear button, active-high
//                digit0  out 4  ones digit (BCD), registered
//                digit1  out 4  tens digit (BCD), registered
//                step    out 1  pulse in the cycle the count changed
//                wrap    out 1  pulse in the cycle the count wrapped
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_event_counter #(
    parameter int DEBOUNCE_W = 11,
    parameter int PRESCALE_W = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_clr,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic       step,
    output logic       wrap
);

    // Both widths need at least two bits for the filter/prescaler to be meaningful.
    if (DEBOUNCE_W < 2 || PRESCALE_W < 2) begin : g_param_check
        $error("bcd_event_counter: DEBOUNCE_W and PRESCALE_W must be >= 2");
    end

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } deb_state_t;

    localparam int                  c_NBTN     = 3;  // index 0=up, 1=dn, 2=clr
    localparam logic [DEBOUNCE_W-1:0] c_CNT_MAX = '1;

    logic [c_NBTN-1:0]     w_raw;
    logic [c_NBTN-1:0]     r_sync1;
    logic [c_NBTN-1:0]     r_sync2;
    deb_state_t            r_state     [c_NBTN];
    deb_state_t            w_state_nxt [c_NBTN];
    logic [DEBOUNCE_W-1:0] r_cnt       [c_NBTN];
    logic [DEBOUNCE_W-1:0] w_cnt_nxt   [c_NBTN];
    logic [c_NBTN-1:0]     w_rise;
    logic [c_NBTN-1:0]     r_evt;

    logic w_tick;
    logic w_up;
    logic w_dn;
    logic w_clr;

    assign w_raw = {btn_clr, btn_dn, btn_up};

    // ------------------------------------------------------------------
    // Synchronisers, debounce state/counters and event pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_evt   <= '0;
            for (int i = 0; i < c_NBTN; i++) begin
                r_state[i] <= LOW;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_evt   <= w_rise;  // registered on the same edge the filter flips
            for (int i = 0; i < c_NBTN; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // The counter only advances while the synchronised input disagrees with
    // the filtered level; any agreement restarts qualification from zero.
    always_comb begin
        w_rise = '0;
        for (int i = 0; i < c_NBTN; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = '0;
            case (r_state[i])
                LOW: begin
                    if (r_sync2[i]) begin
                        if (r_cnt[i] == c_CNT_MAX) begin
                            w_state_nxt[i] = HIGH;
                            w_rise[i]      = 1'b1;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (!r_sync2[i]) begin
                        if (r_cnt[i] == c_CNT_MAX) begin
                            w_state_nxt[i] = LOW;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt[i] = LOW;
                end
            endcase
        end
    end

    assign w_clr = r_evt[2];
    assign w_dn  = r_evt[1];

`ifdef AUTO_COUNT_EN
    // ------------------------------------------------------------------
    // Auto-increment prescaler; a clear restarts the auto-count period.
    // ------------------------------------------------------------------
    logic [PRESCALE_W-1:0] r_prescale;

    always_ff @(posedge clock) begin
        if (!reset || w_clr) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    assign w_tick = &r_prescale;
`else
    assign w_tick = 1'b0;
`endif

    // Tick and button up merge into one up request, so a coincidence is +1.
    assign w_up = r_evt[0] | w_tick;

    // ------------------------------------------------------------------
    // Two-digit BCD count, each digit handled on its own
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            digit0 <= 4'd0;
            digit1 <= 4'd0;
            step   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            if (w_clr) begin
                digit0 <= 4'd0;
                digit1 <= 4'd0;
                step   <= (digit0 != 4'd0) || (digit1 != 4'd0);
            end else if (w_up && !w_dn) begin
                step <= 1'b1;
                if (digit0 == 4'd9) begin
                    digit0 <= 4'd0;
                    if (digit1 == 4'd9) begin
                        digit1 <= 4'd0;
                        wrap   <= 1'b1;
                    end else begin
                        digit1 <= digit1 + 4'd1;
                    end
                end else begin
                    digit0 <= digit0 + 4'd1;
                end
            end else if (w_dn && !w_up) begin
                step <= 1'b1;
                if (digit0 == 4'd0) begin
                    digit0 <= 4'd9;
                    if (digit1 == 4'd0) begin
                        digit1 <= 4'd9;
                        wrap   <= 1'b1;
                    end else begin
                        digit1 <= digit1 - 4'd1;
                    end
                end else begin
                    digit0 <= digit0 - 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_event_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_event_counter
//  Description : Directed self-checking bench for bcd_event_counter with
//                DEBOUNCE_W=3 (press-to-count latency 11 edges) and
//                PRESCALE_W=4. Inputs change and outputs are sampled 1 time
//                unit after each rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_event_counter;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_dn;
    logic       btn_clr;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       step;
    logic       wrap;

    int n_assert = 0;
    int n_fail   = 0;
    int cur      = 0;   // expected count, 0..99

    bcd_event_counter #(
        .DEBOUNCE_W (3),
        .PRESCALE_W (4)
    ) dut (
        .clock   (clk),
        .reset   (rst_n),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .btn_clr (btn_clr),
        .digit0  (digit0),
        .digit1  (digit1),
        .step    (step),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       btn_up  = v;
            1:       btn_dn  = v;
            default: btn_clr = v;
        endcase
    endtask

    // Full press/release of one button; model updated from 'cur'.
    task automatic do_press(input int which, input string tag);
        int  nxt;
        bit  exp_wrap;
        bit  exp_step;
        exp_wrap = 1'b0;
        case (which)
            0: begin nxt = (cur + 1) % 100;  exp_wrap = (cur == 99); end
            1: begin nxt = (cur + 99) % 100; exp_wrap = (cur == 0);  end
            default: nxt = 0;
        endcase
        exp_step = (nxt != cur);
        set_btn(which, 1'b1);
        cyc(10);
        chk({tag, "_pre_cnt"}, {digit1, digit0}, bcd(cur));
        chk({tag, "_pre_step"}, step, 1'b0);
        cyc(1);
        chk({tag, "_cnt"}, {digit1, digit0}, bcd(nxt));
        chk({tag, "_step"}, step, exp_step);
        chk({tag, "_wrap"}, wrap, exp_wrap);
        cur = nxt;
        set_btn(which, 1'b0);
        cyc(12);
    endtask

    initial begin
        bit stepped;
        rst_n   = 1'b0;
        btn_up  = 1'b0;
        btn_dn  = 1'b0;
        btn_clr = 1'b0;

        // 1: reset and idle
        cyc(2);
        chk("rst_cnt", {digit1, digit0}, 8'h00);
        chk("rst_step", step, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        rst_n = 1'b1;
        stepped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (step || wrap) stepped = 1'b1;
        end
        chk("idle_cnt", {digit1, digit0}, 8'h00);
        chk("idle_step", stepped, 1'b0);

        // 2: hold up 20 cycles: exactly one step at edge 11, no auto-repeat
        btn_up = 1'b1;
        cyc(10);
        chk("hold_e10_cnt", {digit1, digit0}, 8'h00);
        cyc(1);
        chk("hold_e11_cnt", {digit1, digit0}, 8'h01);
        chk("hold_e11_step", step, 1'b1);
        cyc(1);
        chk("hold_e12_step", step, 1'b0);
        cyc(8);
        chk("hold_e20_cnt", {digit1, digit0}, 8'h01);
        btn_up = 1'b0;
        cyc(12);
        cur = 1;
        do_press(0, "repress");

        // 3: 5-cycle glitch is rejected
        btn_up = 1'b1;
        cyc(5);
        btn_up = 1'b0;
        stepped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (step) stepped = 1'b1;
        end
        chk("glitch_step", stepped, 1'b0);
        chk("glitch_cnt", {digit1, digit0}, 8'h02);

        // 4: count up through 09->10 and 99->00
        while (cur != 9) do_press(0, "up_to9");
        do_press(0, "up_9to10");
        while (cur != 99) do_press(0, "up_to99");
        do_press(0, "up_99to00");

        // 5: down wrap, then simultaneous up+dn cancels at 42
        do_press(1, "dn_00to99");
        do_press(2, "clr_99");
        while (cur != 42) do_press(0, "up_to42");
        btn_up = 1'b1;
        btn_dn = 1'b1;
        cyc(11);
        chk("cancel_cnt", {digit1, digit0}, 8'h42);
        chk("cancel_step", step, 1'b0);
        cyc(2);
        chk("cancel_cnt2", {digit1, digit0}, 8'h42);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        cyc(12);

        // 6: clear from 37, then reset mid-debounce
        while (cur != 37) do_press(1, "dn_to37");
        do_press(2, "clr_37");
        do_press(2, "clr_00");
        btn_up = 1'b1;
        cyc(7);                       // debounce counter at 5
        rst_n  = 1'b0;
        btn_up = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        stepped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (step) stepped = 1'b1;
        end
        chk("rstmid_step", stepped, 1'b0);
        chk("rstmid_cnt", {digit1, digit0}, 8'h00);

        // held across reset: must re-qualify from zero after release
        btn_up = 1'b1;
        cyc(7);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        chk("requal_e10_cnt", {digit1, digit0}, 8'h00);
        cyc(1);
        chk("requal_e11_cnt", {digit1, digit0}, 8'h01);
        chk("requal_e11_step", step, 1'b1);
        btn_up = 1'b0;
        cyc(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
